// File: rtl/spi_slave_if_if.sv
// SPI-side and RAM-side signal bundle for the SPI slave front end.
// The slave modport is seen by spi_slave_if; the master modport by the SPI master and the RAM.
interface spi_slave_if_if #(
    parameter int DIN_W  = 10,
    parameter int DOUT_W = 8
);
    logic              ss_n;
    logic              mosi;
    logic              miso;
    logic [DIN_W-1:0]  rx_data;
    logic              rx_valid;
    logic [DOUT_W-1:0] tx_data;
    logic              tx_valid;

    modport slave (
        input  ss_n, mosi, tx_data, tx_valid,
        output miso, rx_data, rx_valid
    );

    modport master (
        output ss_n, mosi, tx_data, tx_valid,
        input  miso, rx_data, rx_valid
    );
endinterface

// File: rtl/spi_slave_if.sv
// SPI slave front end for the single-port RAM: MOSI frames become RAM command words, RAM read data is shifted out on MISO.
// Optional macro SPI_RD_GUARD_EN drops read frames whose opcode does not match the read phase.
module spi_slave_if #(
    parameter int DIN_W  = 10,
    parameter int DOUT_W = 8
) (
    input  logic           clk_i,
    input  logic           rst_i,
    spi_slave_if_if.slave  bus
);
    localparam int RXC_W = $clog2(DIN_W + 1);
    localparam int TXC_W = $clog2(DOUT_W + 1);
    localparam logic [RXC_W-1:0] RX_FULL = RXC_W'(DIN_W);
    localparam logic [RXC_W-1:0] RX_LAST = RXC_W'(DIN_W - 1);
    localparam logic [TXC_W-1:0] TX_LAST = TXC_W'(DOUT_W - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CHK_CMD   = 3'd1,
        WRITE     = 3'd2,
        READ_ADD  = 3'd3,
        READ_DATA = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [RXC_W-1:0]   rx_cnt_q, rx_cnt_d;
    logic [DIN_W-1:0]   shift_q, shift_d;
    logic [DIN_W-1:0]   rx_data_q, rx_data_d;
    logic               rx_valid_q, rx_valid_d;
    logic               miso_q, miso_d;
    logic               rd_addr_seen_q, rd_addr_seen_d;
    logic               tx_armed_q, tx_armed_d;
    logic               tx_busy_q, tx_busy_d;
    logic [TXC_W-1:0]   tx_cnt_q, tx_cnt_d;
    logic [DOUT_W-1:0]  tx_shift_q, tx_shift_d;
    logic [DIN_W-1:0]   frame_s;
    logic               guard_ok_s;

    assign frame_s = {shift_q[DIN_W-2:0], bus.mosi};

    // Decide whether a completing frame may be forwarded to the RAM.
    always_comb begin
        guard_ok_s = 1'b1;
`ifdef SPI_RD_GUARD_EN
        if (state_q == READ_ADD) begin
            guard_ok_s = (frame_s[DIN_W-1 -: 2] == 2'b10);
        end else if (state_q == READ_DATA) begin
            guard_ok_s = (frame_s[DIN_W-1 -: 2] == 2'b11);
        end else begin
            guard_ok_s = 1'b1;
        end
`else
        guard_ok_s = 1'b1;
`endif
    end

    // Next-state and datapath logic for the frame FSM and the MISO shifter.
    always_comb begin
        state_d        = state_q;
        rx_cnt_d       = rx_cnt_q;
        shift_d        = shift_q;
        rx_data_d      = rx_data_q;
        rx_valid_d     = 1'b0;
        miso_d         = 1'b0;
        rd_addr_seen_d = rd_addr_seen_q;
        tx_armed_d     = tx_armed_q;
        tx_busy_d      = tx_busy_q;
        tx_cnt_d       = tx_cnt_q;
        tx_shift_d     = tx_shift_q;

        if (bus.ss_n) begin
            // Deselect discards any partial frame or shift but keeps rd_addr_seen.
            state_d    = IDLE;
            rx_cnt_d   = {RXC_W{1'b0}};
            tx_armed_d = 1'b0;
            tx_busy_d  = 1'b0;
            tx_cnt_d   = {TXC_W{1'b0}};
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = CHK_CMD;
                end
                CHK_CMD: begin
                    if (!bus.mosi) begin
                        state_d = WRITE;
                    end else if (rd_addr_seen_q) begin
                        state_d = READ_DATA;
                    end else begin
                        state_d = READ_ADD;
                    end
                end
                WRITE, READ_ADD, READ_DATA: begin
                    if (rx_cnt_q != RX_FULL) begin
                        shift_d  = frame_s;
                        rx_cnt_d = rx_cnt_q + RXC_W'(1);
                        if ((rx_cnt_q == RX_LAST) && guard_ok_s) begin
                            rx_data_d      = frame_s;
                            rx_valid_d     = 1'b1;
                            rd_addr_seen_d = rd_addr_seen_q | (state_q == READ_ADD);
                            tx_armed_d     = (state_q == READ_DATA);
                        end else begin
                            rx_valid_d = 1'b0;
                        end
                    end else if ((state_q == READ_DATA) && tx_busy_q) begin
                        if (tx_cnt_q != {TXC_W{1'b0}}) begin
                            miso_d     = tx_shift_q[DOUT_W-1];
                            tx_shift_d = {tx_shift_q[DOUT_W-2:0], 1'b0};
                            tx_cnt_d   = tx_cnt_q - TXC_W'(1);
                        end else begin
                            tx_busy_d      = 1'b0;
                            rd_addr_seen_d = 1'b0;
                        end
                    end else if ((state_q == READ_DATA) && tx_armed_q && bus.tx_valid) begin
                        // MSB goes straight to MISO; the rest is kept pre-shifted.
                        miso_d     = bus.tx_data[DOUT_W-1];
                        tx_shift_d = {bus.tx_data[DOUT_W-2:0], 1'b0};
                        tx_cnt_d   = TX_LAST;
                        tx_busy_d  = 1'b1;
                        tx_armed_d = 1'b0;
                    end else begin
                        miso_d = 1'b0;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q        <= IDLE;
            rx_cnt_q       <= {RXC_W{1'b0}};
            shift_q        <= {DIN_W{1'b0}};
            rx_data_q      <= {DIN_W{1'b0}};
            rx_valid_q     <= 1'b0;
            miso_q         <= 1'b0;
            rd_addr_seen_q <= 1'b0;
            tx_armed_q     <= 1'b0;
            tx_busy_q      <= 1'b0;
            tx_cnt_q       <= {TXC_W{1'b0}};
            tx_shift_q     <= {DOUT_W{1'b0}};
        end else begin
            state_q        <= state_d;
            rx_cnt_q       <= rx_cnt_d;
            shift_q        <= shift_d;
            rx_data_q      <= rx_data_d;
            rx_valid_q     <= rx_valid_d;
            miso_q         <= miso_d;
            rd_addr_seen_q <= rd_addr_seen_d;
            tx_armed_q     <= tx_armed_d;
            tx_busy_q      <= tx_busy_d;
            tx_cnt_q       <= tx_cnt_d;
            tx_shift_q     <= tx_shift_d;
        end
    end

    assign bus.miso     = miso_q;
    assign bus.rx_data  = rx_data_q;
    assign bus.rx_valid = rx_valid_q;
endmodule

// File: tb/tb_spi_slave_if.sv
// Directed, table-driven bench for spi_slave_if: command frames, read data return on MISO, abort and reset corners.
module tb_spi_slave_if;
    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    spi_slave_if_if #(.DIN_W(10), .DOUT_W(8)) bus ();

    spi_slave_if #(.DIN_W(10), .DOUT_W(8)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    typedef struct {
        logic       mode;
        logic [9:0] frame;
        logic       exp_v;
        logic [9:0] exp_d;
        logic       exp_seen;
    } vec_t;

    vec_t vecs [6];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Full frame from IDLE; leaves ss_n low and checks the one-cycle strobe.
    task automatic send_frame(input logic mode, input logic [9:0] frame,
                              input logic exp_v, input logic [9:0] exp_d, input string tag);
        int early;
        early = 0;
        bus.ss_n = 1'b0;
        bus.mosi = 1'b0;
        step();
        bus.mosi = mode;
        step();
        for (int i = 9; i >= 0; i--) begin
            if (bus.rx_valid) early++;
            bus.mosi = frame[i];
            step();
        end
        chk({tag, " early_valid"}, 32'(early), 32'd0);
        chk({tag, " rx_valid"}, 32'(bus.rx_valid), 32'(exp_v));
        if (exp_v) chk({tag, " rx_data"}, 32'(bus.rx_data), 32'(exp_d));
        bus.mosi = 1'b0;
        step();
        chk({tag, " rx_valid_drop"}, 32'(bus.rx_valid), 32'd0);
    endtask

    initial begin
        logic [7:0] txd;
        logic       seen_exp;

        vecs[0] = '{1'b0, 10'h0A5, 1'b1, 10'h0A5, 1'b0};
        vecs[1] = '{1'b0, 10'h3FF, 1'b1, 10'h3FF, 1'b0};
        vecs[2] = '{1'b0, 10'h000, 1'b1, 10'h000, 1'b0};
        vecs[3] = '{1'b1, 10'h207, 1'b1, 10'h207, 1'b1};
        vecs[4] = '{1'b0, 10'h155, 1'b1, 10'h155, 1'b1};
        vecs[5] = '{1'b1, 10'h3AA, 1'b1, 10'h3AA, 1'b1};

        // Reset with slave selected and MOSI toggling.
        rst = 1'b1;
        bus.ss_n = 1'b0;
        bus.mosi = 1'b0;
        bus.tx_data = 8'h00;
        bus.tx_valid = 1'b0;
        step();
        bus.mosi = 1'b1;
        step();
        chk("reset miso", 32'(bus.miso), 32'd0);
        chk("reset rx_valid", 32'(bus.rx_valid), 32'd0);
        chk("reset rx_data", 32'(bus.rx_data), 32'h000);
        chk("reset state", 32'(dut.state_q), 32'd0);
        rst = 1'b0;
        bus.ss_n = 1'b1;
        bus.mosi = 1'b0;
        step();

        // Table of frames, each closed by deselect.
        for (int v = 0; v < 6; v++) begin
            send_frame(vecs[v].mode, vecs[v].frame, vecs[v].exp_v, vecs[v].exp_d, $sformatf("vec%0d", v));
            bus.ss_n = 1'b1;
            step();
            chk($sformatf("vec%0d state", v), 32'(dut.state_q), 32'd0);
            chk($sformatf("vec%0d seen", v), 32'(dut.rd_addr_seen_q), 32'(vecs[v].exp_seen));
            chk($sformatf("vec%0d miso", v), 32'(bus.miso), 32'd0);
        end

        // Guard case: READ_ADD frame carrying opcode 00.
        rst = 1'b1;
        step();
        rst = 1'b0;
`ifdef SPI_RD_GUARD_EN
        send_frame(1'b1, 10'h0C3, 1'b0, 10'h000, "guard");
        seen_exp = 1'b0;
`else
        send_frame(1'b1, 10'h0C3, 1'b1, 10'h0C3, "guard");
        seen_exp = 1'b1;
`endif
        chk("guard seen", 32'(dut.rd_addr_seen_q), 32'(seen_exp));
        bus.ss_n = 1'b1;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;

        // Read pair with RAM returning 0x5C.
        send_frame(1'b1, 10'h207, 1'b1, 10'h207, "rdaddr");
        bus.ss_n = 1'b1;
        step();
        chk("rdaddr seen", 32'(dut.rd_addr_seen_q), 32'd1);
        send_frame(1'b1, 10'h300, 1'b1, 10'h300, "rddata");
        chk("rddata miso_idle", 32'(bus.miso), 32'd0);
        txd = 8'h5C;
        bus.tx_data = txd;
        bus.tx_valid = 1'b1;
        step();
        bus.tx_valid = 1'b0;
        bus.tx_data = 8'h00;
        for (int b = 7; b >= 0; b--) begin
            chk($sformatf("miso bit%0d", b), 32'(bus.miso), 32'(txd[b]));
            if (b != 0) step();
        end
        step();
        chk("miso after", 32'(bus.miso), 32'd0);
        chk("seen cleared", 32'(dut.rd_addr_seen_q), 32'd0);
        bus.ss_n = 1'b1;
        step();
        chk("rd state idle", 32'(dut.state_q), 32'd0);

        // Reset during the 4th MISO bit.
        send_frame(1'b1, 10'h207, 1'b1, 10'h207, "r5addr");
        bus.ss_n = 1'b1;
        step();
        send_frame(1'b1, 10'h300, 1'b1, 10'h300, "r5data");
        txd = 8'hA3;
        bus.tx_data = txd;
        bus.tx_valid = 1'b1;
        step();
        bus.tx_valid = 1'b0;
        step();
        step();
        step();
        chk("r5 bit4 miso", 32'(bus.miso), 32'(txd[4]));
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("r5 miso", 32'(bus.miso), 32'd0);
        chk("r5 state", 32'(dut.state_q), 32'd0);
        chk("r5 seen", 32'(dut.rd_addr_seen_q), 32'd0);

        // Abort after 6 data bits of a WRITE frame, with a stray tx_valid held high.
        bus.ss_n = 1'b1;
        step();
        bus.tx_valid = 1'b1;
        bus.tx_data = 8'hFF;
        bus.ss_n = 1'b0;
        bus.mosi = 1'b0;
        step();
        step();
        for (int i = 0; i < 6; i++) begin
            bus.mosi = 1'(i % 2);
            step();
            chk($sformatf("abort bit%0d rx_valid", i), 32'(bus.rx_valid), 32'd0);
        end
        bus.ss_n = 1'b1;
        step();
        chk("abort state", 32'(dut.state_q), 32'd0);
        chk("abort rx_valid", 32'(bus.rx_valid), 32'd0);
        chk("abort miso", 32'(bus.miso), 32'd0);
        bus.tx_valid = 1'b0;
        send_frame(1'b0, 10'h1F0, 1'b1, 10'h1F0, "after_abort");
        chk("after_abort miso", 32'(bus.miso), 32'd0);
        bus.ss_n = 1'b1;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
